// File: rtl/spmp_check_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// spmp_check_arbiter_pkg
//
// Shared types for the SPMP check arbiter:
//   - cva6_cfg_t / cva6_cfg_empty : minimal core configuration (physical
//                                   address width PLEN)
//   - priv_lvl_t                  : RISC-V privilege level encoding
//   - pmp_access_t                : one-hot access type presented to the checker
//   - spmp_arb_state_e            : arbiter FSM states
//   - OWNER_IF / OWNER_LSU        : encoding of the owner and priority bits
// -----------------------------------------------------------------------------
package spmp_check_arbiter_pkg;

    typedef struct packed {
        int unsigned PLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 34};

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } spmp_arb_state_e;

    // Owner / priority encoding shared by the arbiter and its grant logic.
    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage : spmp_check_arbiter_pkg

// File: rtl/spmp_check_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// spmp_rr_arb2
//
// Two-way round-robin grant between the fetch and LSU requesters.
// Grants are purely combinational from the request lines and the priority
// flop; the priority flop only moves when the parent reports an accepted
// request, and then points at the requester that was not granted.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_if_i        fetch request valid
//   req_lsu_i       LSU request valid
//   accept_i        a grant was consumed this cycle (update priority)
//   grant_if_o      fetch wins the arbitration this cycle
//   grant_lsu_o     LSU wins the arbitration this cycle
// -----------------------------------------------------------------------------
module spmp_rr_arb2
    import spmp_check_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_if_i,
    input  logic req_lsu_i,
    input  logic accept_i,
    output logic grant_if_o,
    output logic grant_lsu_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        // A lone request always wins; on a tie the priority bit decides.
        grant_if_o  = req_if_i  && (!req_lsu_i || (prio_q == OWNER_IF));
        grant_lsu_o = req_lsu_i && (!req_if_i  || (prio_q == OWNER_LSU));

        prio_d = prio_q;
        if (accept_i) begin
            prio_d = grant_lsu_o ? OWNER_IF : OWNER_LSU;
        end
    end

    // LSU wins the first tie after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= OWNER_LSU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : spmp_rr_arb2

// File: rtl/spmp_check_arbiter.sv
// -----------------------------------------------------------------------------
// spmp_check_arbiter
//
// Shares one SPMP permission checker between instruction fetch and the LSU.
// One request is accepted at a time (round-robin on ties), its operands are
// registered and presented to the external checker, the checker's allow is
// sampled and returned to the originating requester on a valid/ready
// response channel. An SPMP CSR write while a request is in flight forces
// the check to be re-run so the answer always reflects current CSR state.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   if_req_valid_i / if_req_ready_o      fetch request handshake
//   if_addr_i, if_priv_lvl_i             fetch operands (access is EXEC, no HLVX)
//   lsu_req_valid_i / lsu_req_ready_o    LSU request handshake
//   lsu_addr_i, lsu_access_type_i,
//   lsu_priv_lvl_i, lsu_is_hlvx_i        LSU operands
//   if_rsp_valid_o / if_rsp_ready_i,
//   if_rsp_allow_o                       fetch response
//   lsu_rsp_valid_o / lsu_rsp_ready_i,
//   lsu_rsp_allow_o                      LSU response
//   chk_addr_o, chk_access_type_o,
//   chk_priv_lvl_o, chk_is_hlvx_o        registered operands to the checker
//   chk_allow_i                          combinational allow from the checker
//   spmp_update_i                        SPMP CSR write pulse
//   flush_i                              kill any in-flight request
// -----------------------------------------------------------------------------
module spmp_check_arbiter
    import spmp_check_arbiter_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      if_req_valid_i,
    output logic                      if_req_ready_o,
    input  logic [CVA6Cfg.PLEN-1:0]   if_addr_i,
    input  priv_lvl_t                 if_priv_lvl_i,

    input  logic                      lsu_req_valid_i,
    output logic                      lsu_req_ready_o,
    input  logic [CVA6Cfg.PLEN-1:0]   lsu_addr_i,
    input  pmp_access_t               lsu_access_type_i,
    input  priv_lvl_t                 lsu_priv_lvl_i,
    input  logic                      lsu_is_hlvx_i,

    output logic                      if_rsp_valid_o,
    input  logic                      if_rsp_ready_i,
    output logic                      if_rsp_allow_o,

    output logic                      lsu_rsp_valid_o,
    input  logic                      lsu_rsp_ready_i,
    output logic                      lsu_rsp_allow_o,

    output logic [CVA6Cfg.PLEN-1:0]   chk_addr_o,
    output pmp_access_t               chk_access_type_o,
    output priv_lvl_t                 chk_priv_lvl_o,
    output logic                      chk_is_hlvx_o,
    input  logic                      chk_allow_i,

    input  logic                      spmp_update_i,
    input  logic                      flush_i
);

    localparam int unsigned PLEN = CVA6Cfg.PLEN;

    // -------------------------------------------------------------------------
    // State and operand registers
    // -------------------------------------------------------------------------
    spmp_arb_state_e   state_q, state_d;
    logic              owner_q, owner_d;
    logic [PLEN-1:0]   addr_q,  addr_d;
    pmp_access_t       acc_q,   acc_d;
    priv_lvl_t         priv_q,  priv_d;
    logic              hlvx_q,  hlvx_d;
    logic              allow_q, allow_d;

    logic grant_if;
    logic grant_lsu;
    logic accept;
    logic rsp_valid;
    logic owner_rsp_ready;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // Accepting depends only on state, valids, prio and flush, so there is no
    // path from the response ready inputs to the request readies.
    assign accept = (state_q == IDLE) && !flush_i && (grant_if || grant_lsu);

    spmp_rr_arb2 u_rr_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_if_i    (if_req_valid_i),
        .req_lsu_i   (lsu_req_valid_i),
        .accept_i    (accept),
        .grant_if_o  (grant_if),
        .grant_lsu_o (grant_lsu)
    );

    assign if_req_ready_o  = (state_q == IDLE) && !flush_i && grant_if;
    assign lsu_req_ready_o = (state_q == IDLE) && !flush_i && grant_lsu;

    // -------------------------------------------------------------------------
    // Response channel
    // -------------------------------------------------------------------------
    // A flush in RESP withdraws the response in the same cycle so a requester
    // can never complete a handshake on a killed request.
    assign rsp_valid       = (state_q == RESP) && !flush_i;
    assign if_rsp_valid_o  = rsp_valid && (owner_q == OWNER_IF);
    assign lsu_rsp_valid_o = rsp_valid && (owner_q == OWNER_LSU);
    assign if_rsp_allow_o  = if_rsp_valid_o  && allow_q;
    assign lsu_rsp_allow_o = lsu_rsp_valid_o && allow_q;

    assign owner_rsp_ready = (owner_q == OWNER_LSU) ? lsu_rsp_ready_i : if_rsp_ready_i;

    // Checker operands always come from the registers, never from the
    // requesters directly, so the checker sees stable inputs during CHECK.
    assign chk_addr_o        = addr_q;
    assign chk_access_type_o = acc_q;
    assign chk_priv_lvl_o    = priv_q;
    assign chk_is_hlvx_o     = hlvx_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        priv_d  = priv_q;
        hlvx_d  = hlvx_q;
        allow_d = allow_q;

        if (flush_i) begin
            // Flush wins over everything, including a pending handshake.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = CHECK;
                        if (grant_lsu) begin
                            owner_d = OWNER_LSU;
                            addr_d  = lsu_addr_i;
                            acc_d   = lsu_access_type_i;
                            priv_d  = lsu_priv_lvl_i;
                            hlvx_d  = lsu_is_hlvx_i;
                        end else begin
                            owner_d = OWNER_IF;
                            addr_d  = if_addr_i;
                            acc_d   = ACCESS_EXEC;
                            priv_d  = if_priv_lvl_i;
                            hlvx_d  = 1'b0;
                        end
                    end
                end

                CHECK: begin
                    // A CSR write in the sampling cycle may have changed the
                    // checker's answer mid-evaluation; sample again next cycle.
                    if (!spmp_update_i) begin
                        allow_d = chk_allow_i;
                        state_d = RESP;
                    end
                end

                RESP: begin
                    if (owner_rsp_ready) begin
                        // Handshake beats a coincident CSR update.
                        state_d = IDLE;
                    end else if (spmp_update_i) begin
                        state_d = CHECK;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= OWNER_IF;
            addr_q  <= '0;
            acc_q   <= ACCESS_NONE;
            priv_q  <= PRIV_LVL_U;
            hlvx_q  <= 1'b0;
            allow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            priv_q  <= priv_d;
            hlvx_q  <= hlvx_d;
            allow_q <= allow_d;
        end
    end

endmodule : spmp_check_arbiter

// File: tb/tb_spmp_check_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spmp_check_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle all outputs
// are compared against a transaction-level reference model (busy flag,
// evaluate/respond phase, priority, captured operands).
// -----------------------------------------------------------------------------
module tb_spmp_check_arbiter;
    import spmp_check_arbiter_pkg::*;

    localparam int unsigned PLEN = cva6_cfg_empty.PLEN;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_valid, if_req_ready;
    logic [PLEN-1:0]   if_addr;
    priv_lvl_t         if_priv;
    logic              lsu_req_valid, lsu_req_ready;
    logic [PLEN-1:0]   lsu_addr;
    pmp_access_t       lsu_acc;
    priv_lvl_t         lsu_priv;
    logic              lsu_hlvx;
    logic              if_rsp_valid, if_rsp_ready, if_rsp_allow;
    logic              lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_allow;
    logic [PLEN-1:0]   chk_addr;
    pmp_access_t       chk_acc;
    priv_lvl_t         chk_priv;
    logic              chk_hlvx;
    logic              chk_allow;
    logic              spmp_update;
    logic              flush;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    bit              m_busy;    // a request has been accepted and not finished
    bit              m_eval;    // checker result not yet captured
    bit              m_owner;   // 1 = LSU
    bit              m_prio;    // 1 = LSU wins next tie
    bit              m_allow;
    logic [PLEN-1:0] m_addr;
    logic [2:0]      m_acc;
    logic [1:0]      m_priv;
    bit              m_hlvx;

    priv_lvl_t privs [3] = '{PRIV_LVL_U, PRIV_LVL_S, PRIV_LVL_M};

    always #5 clk = ~clk;

    spmp_check_arbiter #(.CVA6Cfg(cva6_cfg_empty)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .if_req_valid_i    (if_req_valid),
        .if_req_ready_o    (if_req_ready),
        .if_addr_i         (if_addr),
        .if_priv_lvl_i     (if_priv),
        .lsu_req_valid_i   (lsu_req_valid),
        .lsu_req_ready_o   (lsu_req_ready),
        .lsu_addr_i        (lsu_addr),
        .lsu_access_type_i (lsu_acc),
        .lsu_priv_lvl_i    (lsu_priv),
        .lsu_is_hlvx_i     (lsu_hlvx),
        .if_rsp_valid_o    (if_rsp_valid),
        .if_rsp_ready_i    (if_rsp_ready),
        .if_rsp_allow_o    (if_rsp_allow),
        .lsu_rsp_valid_o   (lsu_rsp_valid),
        .lsu_rsp_ready_i   (lsu_rsp_ready),
        .lsu_rsp_allow_o   (lsu_rsp_allow),
        .chk_addr_o        (chk_addr),
        .chk_access_type_o (chk_acc),
        .chk_priv_lvl_o    (chk_priv),
        .chk_is_hlvx_o     (chk_hlvx),
        .chk_allow_i       (chk_allow),
        .spmp_update_i     (spmp_update),
        .flush_i           (flush)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_eval  = 0;
        m_owner = 0;
        m_prio  = 1;
        m_allow = 0;
        m_addr  = '0;
        m_acc   = 3'b000;
        m_priv  = 2'b00;
        m_hlvx  = 0;
    endtask

    function automatic bit winner_lsu();
        if (lsu_req_valid && if_req_valid) return m_prio;
        return lsu_req_valid;
    endfunction

    // Compare every output against the model mid-cycle.
    task automatic sample();
        bit any_req, win_lsu, resp;
        @(negedge clk);
        any_req = if_req_valid || lsu_req_valid;
        win_lsu = winner_lsu();
        resp    = m_busy && !m_eval && !flush;
        chk("if_req_ready",  if_req_ready,  !m_busy && !flush && any_req && !win_lsu);
        chk("lsu_req_ready", lsu_req_ready, !m_busy && !flush && any_req && win_lsu);
        chk("if_rsp_valid",  if_rsp_valid,  resp && !m_owner);
        chk("lsu_rsp_valid", lsu_rsp_valid, resp && m_owner);
        chk("if_rsp_allow",  if_rsp_allow,  resp && !m_owner && m_allow);
        chk("lsu_rsp_allow", lsu_rsp_allow, resp && m_owner && m_allow);
        chk("chk_addr",      chk_addr,      m_addr);
        chk("chk_acc",       chk_acc,       m_acc);
        chk("chk_priv",      chk_priv,      m_priv);
        chk("chk_hlvx",      chk_hlvx,      m_hlvx);
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        bit hs;
        if (flush) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (if_req_valid || lsu_req_valid) begin
                m_owner = winner_lsu();
                m_busy  = 1;
                m_eval  = 1;
                m_prio  = !m_owner;
                if (m_owner) begin
                    m_addr = lsu_addr; m_acc = lsu_acc; m_priv = lsu_priv; m_hlvx = lsu_hlvx;
                end else begin
                    m_addr = if_addr; m_acc = 3'b100; m_priv = if_priv; m_hlvx = 0;
                end
            end
        end else if (m_eval) begin
            if (!spmp_update) begin
                m_allow = chk_allow;
                m_eval  = 0;
            end
        end else begin
            hs = m_owner ? lsu_rsp_ready : if_rsp_ready;
            if (hs) begin
                m_busy = 0;
                txn++;
                $display("txn %0d owner=%s addr=%h allow=%0b", txn, m_owner ? "LSU" : "IF", m_addr, m_allow);
            end else if (spmp_update) begin
                m_eval = 1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_addr = '0; if_priv = PRIV_LVL_M;
        lsu_req_valid = 0; lsu_addr = '0; lsu_acc = ACCESS_READ; lsu_priv = PRIV_LVL_S; lsu_hlvx = 0;
        if_rsp_ready = 0; lsu_rsp_ready = 0;
        chk_allow = 0; spmp_update = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        do_reset();

        // Reset state
        sample();
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_chk_addr", chk_addr, 0);
        advance();

        // 1: single LSU READ, response two cycles after accept
        lsu_req_valid = 1; lsu_addr = PLEN'(34'h0_8000_0000); lsu_acc = ACCESS_READ;
        lsu_rsp_ready = 1;
        sample();
        chk("t1_lsu_ready_c0", lsu_req_ready, 1);
        advance();
        lsu_req_valid = 0; chk_allow = 1;
        step();
        sample();
        chk("t1_lsu_rsp_valid_c2", lsu_rsp_valid, 1);
        chk("t1_lsu_rsp_allow_c2", lsu_rsp_allow, 1);
        chk("t1_if_rsp_valid_c2", if_rsp_valid, 0);
        chk("t1_chk_addr", chk_addr, PLEN'(34'h0_8000_0000));
        advance();

        // 2: both valid out of reset, alternating L,I,L,I,L,I
        do_reset();
        if_req_valid = 1; lsu_req_valid = 1; if_rsp_ready = 1; lsu_rsp_ready = 1;
        if_addr = PLEN'(34'h1000); lsu_addr = PLEN'(34'h2000);
        for (int i = 0; i < 6; i++) begin
            chk_allow = 1'($urandom);
            sample();
            chk("t2_grant_lsu", lsu_req_ready, (i % 2) == 0);
            chk("t2_grant_if",  if_req_ready,  (i % 2) == 1);
            advance();
            step();
            step();
        end
        idle_inputs();
        step();

        // 3: CSR update during CHECK, allow changes 1->0
        lsu_rsp_ready = 1;
        lsu_req_valid = 1; lsu_addr = PLEN'(34'h3000); lsu_acc = ACCESS_WRITE;
        step();
        lsu_req_valid = 0; chk_allow = 1; spmp_update = 1;
        step();
        spmp_update = 0; chk_allow = 0;
        sample();
        chk("t3_no_rsp_c2", lsu_rsp_valid, 0);
        advance();
        sample();
        chk("t3_rsp_valid_c3", lsu_rsp_valid, 1);
        chk("t3_rsp_allow_c3", lsu_rsp_allow, 0);
        advance();

        // 4: CSR update while holding a response
        lsu_rsp_ready = 0;
        lsu_req_valid = 1; lsu_addr = PLEN'(34'h4000); lsu_hlvx = 1;
        step();
        lsu_req_valid = 0; chk_allow = 1;
        step();
        spmp_update = 1;
        sample();
        chk("t4_rsp_before", lsu_rsp_valid, 1);
        chk("t4_allow_before", lsu_rsp_allow, 1);
        advance();
        spmp_update = 0; chk_allow = 0;
        sample();
        chk("t4_rsp_dropped", lsu_rsp_valid, 0);
        advance();
        spmp_update = 1; lsu_rsp_ready = 1;
        sample();
        chk("t4_rsp_back", lsu_rsp_valid, 1);
        chk("t4_allow_resampled", lsu_rsp_allow, 0);
        advance();
        spmp_update = 0;
        sample();
        chk("t4_handshake_wins", lsu_rsp_valid, 0);
        advance();

        // 5: flush in CHECK and in RESP, priority preserved
        do_reset();
        lsu_req_valid = 1; lsu_addr = PLEN'(34'h5000);
        step();
        lsu_req_valid = 0; flush = 1;
        step();
        flush = 0; if_req_valid = 1; lsu_req_valid = 1; if_addr = PLEN'(34'h6000);
        sample();
        chk("t5_tie_to_if", if_req_ready, 1);
        advance();
        if_req_valid = 0; lsu_req_valid = 0; chk_allow = 1;
        step();
        flush = 1; if_rsp_ready = 1;
        sample();
        chk("t5_flush_resp_valid", if_rsp_valid, 0);
        advance();
        flush = 0; if_req_valid = 1; lsu_req_valid = 1;
        sample();
        chk("t5_tie_to_lsu", lsu_req_ready, 1);
        advance();
        if_req_valid = 0; lsu_req_valid = 0; lsu_rsp_ready = 1;
        repeat (3) step();

        // 6: asynchronous reset mid-RESP
        idle_inputs();
        if_req_valid = 1; if_addr = PLEN'(34'h7000);
        step();
        if_req_valid = 0; chk_allow = 1;
        step();
        #2 rst_n = 0;
        #1;
        chk("t6_if_rsp_valid", if_rsp_valid, 0);
        chk("t6_if_rsp_allow", if_rsp_allow, 0);
        chk("t6_chk_addr", chk_addr, 0);
        chk("t6_lsu_ready", lsu_req_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        if_req_valid = 1; lsu_req_valid = 1;
        sample();
        chk("t6_tie_to_lsu", lsu_req_ready, 1);
        advance();
        idle_inputs();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if_req_valid  = ($urandom_range(0, 99) < 50);
            lsu_req_valid = ($urandom_range(0, 99) < 50);
            if_addr       = PLEN'({$urandom, $urandom});
            lsu_addr      = PLEN'({$urandom, $urandom});
            lsu_acc       = $urandom_range(0, 1) ? ACCESS_WRITE : ACCESS_READ;
            if_priv       = privs[$urandom_range(0, 2)];
            lsu_priv      = privs[$urandom_range(0, 2)];
            lsu_hlvx      = 1'($urandom);
            if_rsp_ready  = ($urandom_range(0, 99) < 70);
            lsu_rsp_ready = ($urandom_range(0, 99) < 70);
            chk_allow     = 1'($urandom);
            spmp_update   = ($urandom_range(0, 99) < 10);
            flush         = ($urandom_range(0, 99) < 4);
            step();
        end

        idle_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spmp_check_arbiter
